pipeline_hazard_ctrl: RTL and testbench

- Hazard and sequencing controller for the front of the 16-bit five-stage pipeline.
- Drives write-enable and flush controls for the PC register, the IF/ID register and the ID/EX register.
- Resolves four conditions: taken branches, load-use data hazards, multi-cycle shared-memory conflicts between IF and MEM, and an external hold request (debug/serial).
- Also keeps saturating stall and flush statistics counters.

---
 rtl/pipeline_hazard_ctrl.sv | 162 ++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Front-end hazard and sequencing controller for the 16-bit five-stage pipeline.
// Handles branch flushes, load-use bubbles, IF/MEM memory conflicts and external hold.
module pipeline_hazard_ctrl #(
  parameter int REG_W    = 4,
  parameter int MEM_WAIT = 2,
  parameter int CNT_W    = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [REG_W-1:0] id_rs,
  input  logic             id_rs_used,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_rt_used,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mem_read,
  input  logic             branch_taken,
  input  logic             mem_imem_access,
  input  logic             hold_req,
  output logic             hold_ack,
  output logic             pc_write_en,
  output logic             if_id_write_en,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    MEM_STALL = 2'd1,
    HOLD      = 2'd2
  } state_t;

  localparam logic [3:0]       WAIT_INIT = 4'(MEM_WAIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t           state_q, state_d;
  logic [3:0]       wait_q, wait_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  logic rs_hit;
  logic rt_hit;
  logic load_use;

  // Load in EX whose destination feeds an operand read in ID.
  always_comb begin
    rs_hit   = id_rs_used && (id_rs == ex_rd);
    rt_hit   = id_rt_used && (id_rt == ex_rd);
    load_use = ex_mem_read && (rs_hit || rt_hit);
  end

  // Next-state and zero-latency pipeline controls.
  always_comb begin
    state_d        = state_q;
    wait_d         = wait_q;
    pc_write_en    = 1'b1;
    if_id_write_en = 1'b1;
    if_id_flush    = 1'b0;
    id_ex_bubble   = 1'b0;
    hold_ack       = 1'b0;
    unique case (state_q)
      RUN: begin
        if (branch_taken) begin
          // Wrong-path instruction is discarded, so nothing else matters.
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
        end else if (mem_imem_access) begin
          pc_write_en    = 1'b0;
          if_id_write_en = 1'b0;
          if_id_flush    = 1'b1;
          if (MEM_WAIT > 1) begin
            state_d = MEM_STALL;
            wait_d  = WAIT_INIT;
          end
        end else begin
          if (load_use) begin
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
            id_ex_bubble   = 1'b1;
          end
          if (hold_req) begin
            state_d = HOLD;
          end
        end
      end
      MEM_STALL: begin
        pc_write_en    = 1'b0;
        if_id_write_en = 1'b0;
        if_id_flush    = 1'b1;
        if (branch_taken) begin
          id_ex_bubble = 1'b1;
        end
        if (wait_q <= 4'd1) begin
          state_d = RUN;
          wait_d  = 4'd0;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      HOLD: begin
        // EX/MEM are frozen by the holder; only hold_req is observed.
        pc_write_en    = 1'b0;
        if_id_write_en = 1'b0;
        hold_ack       = 1'b1;
        if (!hold_req) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
        wait_d  = 4'd0;
      end
    endcase
    if (RST) begin
      pc_write_en    = 1'b0;
      if_id_write_en = 1'b0;
      if_id_flush    = 1'b1;
      id_ex_bubble   = 1'b1;
      hold_ack       = 1'b0;
    end
  end

  // Saturating statistics next values.
  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (!pc_write_en && (stall_q != CNT_MAX)) begin
      stall_d = stall_q + CNT_ONE;
    end
    if (if_id_flush && (flush_q != CNT_MAX)) begin
      flush_d = flush_q + CNT_ONE;
    end
  end

  // Sequencer state and wait counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= RUN;
      wait_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Statistics counters; reset cycles are not counted.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl.
// Three builds: default, MEM_WAIT=1, and CNT_W=4 for saturation.
module tb_pipeline_hazard_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic [3:0] id_rs, id_rt, ex_rd;
  logic       id_rs_used, id_rt_used, ex_mem_read;
  logic       branch_taken, mem_imem_access, hold_req;

  logic        m_ack, m_pc, m_ifid, m_fl, m_bub;
  logic [15:0] m_stall, m_flush;
  logic        w_ack, w_pc, w_ifid, w_fl, w_bub;
  logic [15:0] w_stall, w_flush;
  logic        c_ack, c_pc, c_ifid, c_fl, c_bub;
  logic [3:0]  c_stall, c_flush;

  logic [4:0] m_ctl, w_ctl;
  assign m_ctl = {m_pc, m_ifid, m_fl, m_bub, m_ack};
  assign w_ctl = {w_pc, w_ifid, w_fl, w_bub, w_ack};

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  pipeline_hazard_ctrl #(.REG_W(4), .MEM_WAIT(2), .CNT_W(16)) u_main (
    .CLK(CLK), .RST(RST),
    .id_rs(id_rs), .id_rs_used(id_rs_used),
    .id_rt(id_rt), .id_rt_used(id_rt_used),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .branch_taken(branch_taken), .mem_imem_access(mem_imem_access),
    .hold_req(hold_req), .hold_ack(m_ack),
    .pc_write_en(m_pc), .if_id_write_en(m_ifid),
    .if_id_flush(m_fl), .id_ex_bubble(m_bub),
    .stall_cnt(m_stall), .flush_cnt(m_flush)
  );

  pipeline_hazard_ctrl #(.REG_W(4), .MEM_WAIT(1), .CNT_W(16)) u_w1 (
    .CLK(CLK), .RST(RST),
    .id_rs(id_rs), .id_rs_used(id_rs_used),
    .id_rt(id_rt), .id_rt_used(id_rt_used),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .branch_taken(branch_taken), .mem_imem_access(mem_imem_access),
    .hold_req(hold_req), .hold_ack(w_ack),
    .pc_write_en(w_pc), .if_id_write_en(w_ifid),
    .if_id_flush(w_fl), .id_ex_bubble(w_bub),
    .stall_cnt(w_stall), .flush_cnt(w_flush)
  );

  pipeline_hazard_ctrl #(.REG_W(4), .MEM_WAIT(2), .CNT_W(4)) u_c4 (
    .CLK(CLK), .RST(RST),
    .id_rs(id_rs), .id_rs_used(id_rs_used),
    .id_rt(id_rt), .id_rt_used(id_rt_used),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .branch_taken(branch_taken), .mem_imem_access(mem_imem_access),
    .hold_req(hold_req), .hold_ack(c_ack),
    .pc_write_en(c_pc), .if_id_write_en(c_ifid),
    .if_id_flush(c_fl), .id_ex_bubble(c_bub),
    .stall_cnt(c_stall), .flush_cnt(c_flush)
  );

  task automatic idle_inputs();
    id_rs           = 4'd0;
    id_rt           = 4'd0;
    ex_rd           = 4'd0;
    id_rs_used      = 1'b0;
    id_rt_used      = 1'b0;
    ex_mem_read     = 1'b0;
    branch_taken    = 1'b0;
    mem_imem_access = 1'b0;
    hold_req        = 1'b0;
  endtask

  // ctl = {pc_we, ifid_we, flush, bubble, ack}
  task automatic test_reset();
    @(negedge CLK);
    RST = 1'b1;
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (m_ctl !== 5'b00110) begin
        failures++;
        $display("FAIL reset_ctl[%0d] got=%b exp=00110", i, m_ctl);
      end
      @(negedge CLK);
    end
    RST = 1'b0;
    #1;
    checks++;
    if (m_ctl !== 5'b11000) begin
      failures++;
      $display("FAIL post_reset_ctl got=%b exp=11000", m_ctl);
    end
    checks++;
    if ({m_stall, m_flush} !== 32'd0) begin
      failures++;
      $display("FAIL post_reset_cnt got=%0d/%0d exp=0/0", m_stall, m_flush);
    end
  endtask

  task automatic test_load_use();
    @(negedge CLK);
    ex_mem_read = 1'b1; ex_rd = 4'd3; id_rs = 4'd3; id_rs_used = 1'b1;
    #1;
    checks++;
    if (m_ctl !== 5'b00010) begin
      failures++;
      $display("FAIL lu_rs_ctl got=%b exp=00010", m_ctl);
    end
    @(negedge CLK);
    idle_inputs();
    #1;
    checks++;
    if (m_ctl !== 5'b11000 || m_stall !== 16'd1) begin
      failures++;
      $display("FAIL lu_after got=%b/%0d exp=11000/1", m_ctl, m_stall);
    end
    @(negedge CLK);
    ex_mem_read = 1'b1; ex_rd = 4'd3; id_rs = 4'd3; id_rs_used = 1'b0;
    #1;
    checks++;
    if (m_ctl !== 5'b11000) begin
      failures++;
      $display("FAIL lu_unused_ctl got=%b exp=11000", m_ctl);
    end
    @(negedge CLK);
    ex_mem_read = 1'b1; ex_rd = 4'd7; id_rs = 4'd5; id_rs_used = 1'b1;
    id_rt = 4'd7; id_rt_used = 1'b1;
    #1;
    checks++;
    if (m_ctl !== 5'b00010) begin
      failures++;
      $display("FAIL lu_rt_ctl got=%b exp=00010", m_ctl);
    end
    @(negedge CLK);
    idle_inputs();
    #1;
    checks++;
    if (m_stall !== 16'd2 || m_flush !== 16'd0) begin
      failures++;
      $display("FAIL lu_cnt got=%0d/%0d exp=2/0", m_stall, m_flush);
    end
  endtask

  task automatic test_mem_conflict();
    @(negedge CLK);
    mem_imem_access = 1'b1;
    #1;
    checks++;
    if (m_ctl !== 5'b00100 || w_ctl !== 5'b00100) begin
      failures++;
      $display("FAIL mc_first got=%b/%b exp=00100/00100", m_ctl, w_ctl);
    end
    @(negedge CLK);
    mem_imem_access = 1'b0;
    #1;
    checks++;
    if (m_ctl !== 5'b00100) begin
      failures++;
      $display("FAIL mc_second got=%b exp=00100", m_ctl);
    end
    checks++;
    if (w_ctl !== 5'b11000) begin
      failures++;
      $display("FAIL mc_w1_done got=%b exp=11000", w_ctl);
    end
    @(negedge CLK);
    #1;
    checks++;
    if (m_ctl !== 5'b11000 || m_stall !== 16'd4 || m_flush !== 16'd2) begin
      failures++;
      $display("FAIL mc_done got=%b/%0d/%0d exp=11000/4/2",
               m_ctl, m_stall, m_flush);
    end
    checks++;
    if (w_stall !== 16'd3 || w_flush !== 16'd1) begin
      failures++;
      $display("FAIL mc_w1_cnt got=%0d/%0d exp=3/1", w_stall, w_flush);
    end
  endtask

  task automatic test_branch();
    @(negedge CLK);
    branch_taken = 1'b1;
    ex_mem_read = 1'b1; ex_rd = 4'd3; id_rs = 4'd3; id_rs_used = 1'b1;
    #1;
    checks++;
    if ({m_pc, m_fl, m_bub, m_ack} !== 4'b1110) begin
      failures++;
      $display("FAIL br_lu got=%b exp=1110", {m_pc, m_fl, m_bub, m_ack});
    end
    @(negedge CLK);
    idle_inputs();
    #1;
    checks++;
    if (m_stall !== 16'd4 || m_flush !== 16'd3) begin
      failures++;
      $display("FAIL br_cnt got=%0d/%0d exp=4/3", m_stall, m_flush);
    end
    mem_imem_access = 1'b1;
    @(negedge CLK);
    mem_imem_access = 1'b0;
    branch_taken = 1'b1;
    #1;
    checks++;
    if (m_ctl !== 5'b00110) begin
      failures++;
      $display("FAIL br_in_stall got=%b exp=00110", m_ctl);
    end
    @(negedge CLK);
    branch_taken = 1'b0;
    #1;
    checks++;
    if (m_ctl !== 5'b11000 || m_stall !== 16'd6 || m_flush !== 16'd5) begin
      failures++;
      $display("FAIL br_stall_end got=%b/%0d/%0d exp=11000/6/5",
               m_ctl, m_stall, m_flush);
    end
  endtask

  task automatic test_hold();
    @(negedge CLK);
    hold_req = 1'b1;
    #1;
    checks++;
    if (m_ctl !== 5'b11000) begin
      failures++;
      $display("FAIL hold_req_cycle got=%b exp=11000", m_ctl);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      hold_req     = (i < 4);
      branch_taken = (i == 1);
      #1;
      checks++;
      if (m_ctl !== 5'b00001) begin
        failures++;
        $display("FAIL hold_cycle[%0d] got=%b exp=00001", i, m_ctl);
      end
    end
    @(negedge CLK);
    idle_inputs();
    #1;
    checks++;
    if (m_ctl !== 5'b11000 || m_stall !== 16'd11 || m_flush !== 16'd5) begin
      failures++;
      $display("FAIL hold_release got=%b/%0d/%0d exp=11000/11/5",
               m_ctl, m_stall, m_flush);
    end
  endtask

  task automatic test_reset_in_hold();
    @(negedge CLK);
    hold_req = 1'b1;
    @(negedge CLK);
    RST = 1'b1;
    #1;
    checks++;
    if (m_ctl !== 5'b00110) begin
      failures++;
      $display("FAIL rst_in_hold got=%b exp=00110", m_ctl);
    end
    @(negedge CLK);
    RST = 1'b0;
    #1;
    checks++;
    if (m_ctl !== 5'b11000 || m_stall !== 16'd0 || m_flush !== 16'd0) begin
      failures++;
      $display("FAIL rst_hold_after got=%b/%0d/%0d exp=11000/0/0",
               m_ctl, m_stall, m_flush);
    end
    @(negedge CLK);
    hold_req = 1'b0;
    #1;
    checks++;
    if (m_ack !== 1'b1) begin
      failures++;
      $display("FAIL rehold_ack got=%b exp=1", m_ack);
    end
    @(negedge CLK);
    #1;
    checks++;
    if (m_ctl !== 5'b11000 || m_stall !== 16'd1) begin
      failures++;
      $display("FAIL rehold_end got=%b/%0d exp=11000/1", m_ctl, m_stall);
    end
  endtask

  task automatic test_saturation();
    @(negedge CLK);
    ex_mem_read = 1'b1; ex_rd = 4'd9; id_rt = 4'd9; id_rt_used = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
    end
    idle_inputs();
    #1;
    checks++;
    if (c_stall !== 4'd15 || c_flush !== 4'd0) begin
      failures++;
      $display("FAIL sat_c4 got=%0d/%0d exp=15/0", c_stall, c_flush);
    end
    checks++;
    if (m_stall !== 16'd21) begin
      failures++;
      $display("FAIL sat_main got=%0d exp=21", m_stall);
    end
    @(negedge CLK);
    #1;
    checks++;
    if (c_stall !== 4'd15 || c_pc !== 1'b1) begin
      failures++;
      $display("FAIL sat_hold got=%0d/%b exp=15/1", c_stall, c_pc);
    end
  endtask

  initial begin
    RST = 1'b1;
    idle_inputs();
    test_reset();
    test_load_use();
    test_mem_conflict();
    test_branch();
    test_hold();
    test_reset_in_hold();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
